// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

    localparam int          INST_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT       = 2'd0,
        ST_RUN        = 2'd1,
        ST_ECALL_WAIT = 2'd2,
        ST_FAULT      = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/ifetch_next_pc.sv
// Combinational next-PC selection for the instruction being accepted,
// plus the misaligned-target check on taken jumps/branches.
module ifetch_next_pc
    import ifetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        branch_i,
    input  logic        branch_taken_i,
    input  logic        jal_i,
    input  logic        jalr_i,
    input  logic [31:0] imm32_i,
    input  logic [31:0] rs1_data_i,
    output logic [31:0] next_pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        misaligned_o
);

    logic [31:0] pc_rel;
    logic [31:0] jalr_tgt;
    logic        redirect;

    assign pc_plus4_o = pc_i + 32'd4;
    assign pc_rel     = pc_i + imm32_i;
    assign jalr_tgt   = (rs1_data_i + imm32_i) & 32'hFFFF_FFFE;

    always_comb begin
        next_pc_o = pc_plus4_o;
        redirect  = 1'b0;
        if (jalr_i) begin
            next_pc_o = jalr_tgt;
            redirect  = 1'b1;
        end else if (jal_i) begin
            next_pc_o = pc_rel;
            redirect  = 1'b1;
        end else if (branch_i && branch_taken_i) begin
            next_pc_o = pc_rel;
            redirect  = 1'b1;
        end
    end

    // Fall-through targets are always word aligned; only redirects can fault.
    assign misaligned_o = redirect & next_pc_o[1];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: owns the PC, drives a 1-cycle-latency BRAM and
// presents one inst per cycle. Optional retire counter: IFETCH_RETIRE_CNT_EN.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          IMEM_ADDR_W = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inst_ready,
    input  logic                   Branch,
    input  logic                   jal_flag,
    input  logic                   jalr_flag,
    input  logic                   ecall_flag,
    input  logic                   branch_taken,
    input  logic [31:0]            imm32,
    input  logic [31:0]            rs1_data,
    input  logic                   io_done,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0]      imem_rdata,
    output logic [INST_W-1:0]      inst,
    output logic                   inst_valid,
    output logic [31:0]            pc,
    output logic [31:0]            pc_plus4,
    output logic                   fault,
    output logic [31:0]            retire_cnt
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         fault_q, fault_d;
    logic [31:0]  next_pc;
    logic         misaligned;
    logic         accept;

    ifetch_next_pc u_next_pc (
        .pc_i           (pc_q),
        .branch_i       (Branch),
        .branch_taken_i (branch_taken),
        .jal_i          (jal_flag),
        .jalr_i         (jalr_flag),
        .imm32_i        (imm32),
        .rs1_data_i     (rs1_data),
        .next_pc_o      (next_pc),
        .pc_plus4_o     (pc_plus4),
        .misaligned_o   (misaligned)
    );

    assign inst_valid = (state_q == ST_RUN);
    assign accept     = inst_valid & inst_ready;
    assign inst       = imem_rdata;
    assign pc         = pc_q;
    assign fault      = fault_q;

    // Presenting the next address on accept gives back-to-back fetch; otherwise
    // re-reading pc keeps inst stable across stalls and waits.
    assign imem_addr  = accept ? next_pc[IMEM_ADDR_W+1:2] : pc_q[IMEM_ADDR_W+1:2];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (accept) begin
                    if (misaligned) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end else if (ecall_flag) begin
                        state_d = ST_ECALL_WAIT;
                        pc_d    = pc_plus4;
                    end else begin
                        pc_d    = next_pc;
                    end
                end
            end
            ST_ECALL_WAIT: if (io_done) state_d = ST_RUN;
            ST_FAULT:      state_d = ST_FAULT;
            default:       state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

`ifdef IFETCH_RETIRE_CNT_EN
    logic [31:0] retire_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_q <= 32'h0;
        end else if (accept) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign retire_cnt = retire_q;
`else
    assign retire_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Table-driven check of ifetch_unit against hand-computed PC/address traces.
module tb_ifetch_unit;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          inst_ready, Branch, jal_flag, jalr_flag, ecall_flag, branch_taken;
    logic [31:0]   imm32, rs1_data;
    logic          io_done;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic [31:0]   inst;
    logic          inst_valid;
    logic [31:0]   pc, pc_plus4;
    logic          fault;
    logic [31:0]   retire_cnt;

    logic [31:0]   mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifetch_unit #(.RESET_PC(32'h0), .IMEM_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .inst_ready(inst_ready), .Branch(Branch),
        .jal_flag(jal_flag), .jalr_flag(jalr_flag), .ecall_flag(ecall_flag),
        .branch_taken(branch_taken), .imm32(imm32), .rs1_data(rs1_data),
        .io_done(io_done), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .inst(inst), .inst_valid(inst_valid), .pc(pc), .pc_plus4(pc_plus4),
        .fault(fault), .retire_cnt(retire_cnt)
    );

    always @(posedge clk) imem_rdata <= mem[imem_addr];

    typedef struct {
        logic        rst, rdy, br, tk, jal, jalr, ec, io;
        logic [31:0] imm, rs1;
        logic        ev;
        logic [31:0] epc;
        logic [13:0] eaddr;
        logic        ef;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic rdy, input logic br, input logic tk,
                       input logic jal, input logic jalr, input logic ec, input logic io,
                       input logic [31:0] imm, input logic [31:0] rs1,
                       input logic ev, input logic [31:0] epc, input logic [13:0] eaddr,
                       input logic ef);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.br = br; v.tk = tk; v.jal = jal; v.jalr = jalr;
        v.ec = ec; v.io = io; v.imm = imm; v.rs1 = rs1;
        v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.ef = ef;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int row);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; inst_ready = v.rdy; Branch = v.br; branch_taken = v.tk;
        jal_flag = v.jal; jalr_flag = v.jalr; ecall_flag = v.ec; io_done = v.io;
        imm32 = v.imm; rs1_data = v.rs1;
    endtask

    initial begin
        logic [31:0] exp_rc;
        logic [31:0] exp_p4;
        logic [13:0] widx;
        vec_t        z;
        int          n, guard;

        for (int i = 0; i < (1 << AW); i++) begin
            widx = i[13:0];
            mem[i] = {16'hA5A5, 2'b00, widx};
        end
        mem[0] = 32'h0000_0013;

        //   rst rdy br tk jal jalr ec io imm           rs1           ev epc           addr      f
        add(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 32'h0,        14'h0,    0); // 0 reset state
        add(0, 1, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 32'h0,        14'h0,    0); // BOOT
        add(0, 1, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         1, 32'h0,        14'h1,    0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         1, 32'h4,        14'h2,    0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         1, 32'h8,        14'h3,    0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         1, 32'hC,        14'h3,    0); // 5 stall x3
        add(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         1, 32'hC,        14'h3,    0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         1, 32'hC,        14'h3,    0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         1, 32'hC,        14'h4,    0);
        add(0, 1, 0, 0, 1, 0, 0, 0, 32'h20,        32'h0,         1, 32'h10,       14'hC,    0); // JAL
        add(0, 1, 0, 0, 1, 0, 0, 0, 32'h10,        32'h0,         1, 32'h30,       14'h10,   0); // 10
        add(0, 1, 1, 1, 0, 0, 0, 0, 32'hFFFF_FFF0, 32'h0,         1, 32'h40,       14'hC,    0); // taken
        add(0, 1, 0, 0, 1, 0, 0, 0, 32'h10,        32'h0,         1, 32'h30,       14'h10,   0);
        add(0, 1, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFF0, 32'h0,         1, 32'h40,       14'h11,   0); // not taken
        add(0, 1, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFDC, 32'h0,         1, 32'h44,       14'h8,    0);
        add(0, 1, 0, 0, 0, 0, 1, 1, 32'h0,         32'h0,         1, 32'h20,       14'h9,    0); // 15 ecall+io same cycle
        add(0, 1, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 32'h24,       14'h9,    0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 32'h24,       14'h9,    0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 32'h24,       14'h9,    0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 32'h24,       14'h9,    0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 32'h24,       14'h9,    0); // 20
        add(0, 1, 0, 0, 0, 0, 0, 1, 32'h0,         32'h0,         0, 32'h24,       14'h9,    0); // io_done
        add(0, 1, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFE4, 32'h0,         1, 32'h24,       14'h2,    0);
        add(0, 1, 0, 0, 0, 1, 0, 0, 32'h3,         32'h101,       1, 32'h8,        14'h41,   0); // JALR
        add(0, 1, 0, 0, 1, 0, 0, 0, 32'hFFFF_FF04, 32'h0,         1, 32'h104,      14'h2,    0);
        add(0, 1, 0, 0, 0, 1, 0, 0, 32'h0,         32'h102,       1, 32'h8,        14'h40,   0); // 25 misaligned
        add(0, 1, 0, 0, 1, 0, 0, 0, 32'h20,        32'h0,         0, 32'h8,        14'h2,    1); // FAULT
        add(0, 1, 0, 0, 0, 0, 0, 1, 32'h0,         32'h0,         0, 32'h8,        14'h2,    1);
        add(1, 1, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 32'h8,        14'h2,    1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 32'h0,        14'h0,    0);
        add(0, 1, 0, 0, 0, 0, 1, 0, 32'h0,         32'h0,         1, 32'h0,        14'h1,    0); // 30 ecall
        add(1, 1, 0, 0, 0, 0, 0, 1, 32'h0,         32'h0,         0, 32'h4,        14'h1,    0); // rst in wait
        add(0, 1, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 32'h0,        14'h0,    0);
        add(0, 1, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'h0,         1, 32'h0,        14'h3FFF, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         1, 32'hFFFF_FFFC, 14'h0,   0); // wrap
        add(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         1, 32'h0,        14'h0,    0);

        z = vecs[0];
        drive(z);
        repeat (2) @(posedge clk);
        exp_rc = 32'h0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            exp_p4 = vecs[i].epc + 32'd4;
            chk("inst_valid", {31'b0, inst_valid}, {31'b0, vecs[i].ev}, i);
            chk("pc", pc, vecs[i].epc, i);
            chk("pc_plus4", pc_plus4, exp_p4, i);
            chk("imem_addr", {18'b0, imem_addr}, {18'b0, vecs[i].eaddr}, i);
            chk("fault", {31'b0, fault}, {31'b0, vecs[i].ef}, i);
            if (vecs[i].ev)
                chk("inst", inst, mem[vecs[i].epc[15:2]], i);
`ifdef IFETCH_RETIRE_CNT_EN
            chk("retire_cnt", retire_cnt, exp_rc, i);
`else
            chk("retire_cnt", retire_cnt, 32'h0, i);
`endif
            if (vecs[i].rst) exp_rc = 32'h0;
            else if (vecs[i].ev && vecs[i].rdy) exp_rc = exp_rc + 32'd1;
        end

        // Ten back-to-back accepts from reset.
        @(negedge clk);
        z.rst = 1'b1; z.rdy = 1'b0; z.io = 1'b0;
        drive(z);
        @(negedge clk);
        z.rst = 1'b0; z.rdy = 1'b1;
        drive(z);
        n = 0;
        guard = 0;
        while (n < 10 && guard < 40) begin
            @(negedge clk);
            #1;
            if (inst_valid) n++;
            guard++;
        end
        chk("accept_count", n, 10, 100);
        @(negedge clk);
        inst_ready = 1'b0;
        #1;
        chk("pc_after_10", pc, 32'd40, 101);
        chk("valid_after_10", {31'b0, inst_valid}, 32'd1, 101);
`ifdef IFETCH_RETIRE_CNT_EN
        chk("retire_after_10", retire_cnt, 32'd10, 101);
`else
        chk("retire_after_10", retire_cnt, 32'd0, 101);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
